// File: rtl/xadc_drp_sequencer.sv
// ---------------------------------------------------------------------------
// xadc_drp_sequencer
//
// Purpose: walks a 4-bit channel mask on every XADC end-of-conversion and
// issues one DRP read per enabled channel. The 12-bit results are captured
// into per-channel registers for the LED/display logic.
//
// Ports:
//   CLK100MHZ     system clock, also the DRP clock
//   reset_in      synchronous active-high reset
//   eoc_in        end-of-conversion pulse from xadc_wiz_0
//   ch_mask[3:0]  channel enables (VP/VN, VAUX2, VAUX3, VAUX10), latched per frame
//   clr_err       clears the sticky error flags
//   daddr_out     DRP address
//   den_out       DRP enable, one-cycle pulse
//   dwe_out       DRP write enable, tied 0
//   di_out        DRP write data, tied 0
//   do_in         DRP read data
//   drdy_in       DRP data ready
//   result0..3    latest 12-bit result per channel (do_in[15:4])
//   result_valid  one-cycle pulse per channel when its result updates
//   frame_done    one-cycle pulse at the end of a scan
//   busy          high whenever the sequencer is not idle
//   timeout_err   sticky, a read was abandoned after TIMEOUT_CYCLES
//   overrun_err   sticky, an EOC was lost
//
// Build option: XADC_SEQ_AVG_EN turns each result into an IIR average
// (new = (3*old + sample) >> 2). Without it the raw sample is stored.
// ---------------------------------------------------------------------------
module xadc_drp_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK100MHZ,
    input  logic        reset_in,
    input  logic        eoc_in,
    input  logic [3:0]  ch_mask,
    input  logic        clr_err,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    output logic [15:0] di_out,
    input  logic [15:0] do_in,
    input  logic        drdy_in,
    output logic [11:0] result0,
    output logic [11:0] result1,
    output logic [11:0] result2,
    output logic [11:0] result3,
    output logic [3:0]  result_valid,
    output logic        frame_done,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  scan_mask_q, scan_mask_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        den_q, den_d;
    logic [11:0] result_q [4];
    logic [11:0] result_d [4];
    logic [3:0]  result_valid_q, result_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_err_q, overrun_err_d;
    logic        eoc_pending_q, eoc_pending_d;
    logic        timeout_set;
    logic        overrun_set;
    logic [3:0]  remaining;
`ifdef XADC_SEQ_AVG_EN
    logic [3:0]  primed_q, primed_d;
    logic [13:0] avg_acc;
`endif

    // Lowest enabled channel in a mask; callers only use it on non-zero masks.
    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [6:0] ch_addr(input logic [1:0] i);
        case (i)
            2'd0:    return 7'h03;
            2'd1:    return 7'h12;
            2'd2:    return 7'h13;
            default: return 7'h1A;
        endcase
    endfunction

    // Next-state logic. Visited channels are cleared from scan_mask so the
    // remaining bits directly give the next channel and the end of the frame.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        scan_mask_d    = scan_mask_q;
        cnt_d          = cnt_q;
        daddr_d        = daddr_q;
        den_d          = 1'b0;
        result_d       = result_q;
        result_valid_d = 4'b0000;
        frame_done_d   = 1'b0;
        eoc_pending_d  = eoc_pending_q;
        timeout_set    = 1'b0;
        overrun_set    = 1'b0;
        remaining      = scan_mask_q & ~(4'b0001 << idx_q);
`ifdef XADC_SEQ_AVG_EN
        primed_d       = primed_q;
        avg_acc        = 14'd0;
`endif

        case (state_q)
            S_IDLE: begin
                if (eoc_in || eoc_pending_q) begin
                    // A fresh EOC arriving while a queued one is consumed stays queued.
                    eoc_pending_d = eoc_pending_q && eoc_in;
                    if (ch_mask != 4'b0000) begin
                        scan_mask_d = ch_mask;
                        idx_d       = lowest_bit(ch_mask);
                        daddr_d     = ch_addr(lowest_bit(ch_mask));
                        den_d       = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // drdy is checked first so a response on the last allowed cycle wins.
                if (drdy_in || cnt_q == TIMEOUT_LIMIT) begin
                    if (drdy_in) begin
                        result_valid_d[idx_q] = 1'b1;
`ifdef XADC_SEQ_AVG_EN
                        if (primed_q[idx_q]) begin
                            avg_acc = 14'(result_q[idx_q]) * 14'd3 + 14'(do_in[15:4]);
                            result_d[idx_q] = avg_acc[13:2];
                        end else begin
                            result_d[idx_q] = do_in[15:4];
                            primed_d[idx_q] = 1'b1;
                        end
`else
                        result_d[idx_q] = do_in[15:4];
`endif
                    end else begin
                        timeout_set = 1'b1;
                    end
                    scan_mask_d  = remaining;
                    frame_done_d = (remaining == 4'b0000);
                    cnt_d        = 8'd0;
                    state_d      = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (scan_mask_q != 4'b0000) begin
                    idx_d   = lowest_bit(scan_mask_q);
                    daddr_d = ch_addr(lowest_bit(scan_mask_q));
                    den_d   = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // EOCs during a frame queue one deep; a second one is an overrun.
        if (state_q != S_IDLE && eoc_in) begin
            if (eoc_pending_q) overrun_set   = 1'b1;
            else               eoc_pending_d = 1'b1;
        end

        // Set has priority over clear on the sticky flags.
        timeout_err_d = (timeout_err_q && !clr_err) || timeout_set;
        overrun_err_d = (overrun_err_q && !clr_err) || overrun_set;
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            state_q        <= S_IDLE;
            idx_q          <= 2'd0;
            scan_mask_q    <= 4'b0000;
            cnt_q          <= 8'd0;
            daddr_q        <= 7'd0;
            den_q          <= 1'b0;
            for (int i = 0; i < 4; i++) result_q[i] <= 12'd0;
            result_valid_q <= 4'b0000;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            overrun_err_q  <= 1'b0;
            eoc_pending_q  <= 1'b0;
`ifdef XADC_SEQ_AVG_EN
            primed_q       <= 4'b0000;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            scan_mask_q    <= scan_mask_d;
            cnt_q          <= cnt_d;
            daddr_q        <= daddr_d;
            den_q          <= den_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            overrun_err_q  <= overrun_err_d;
            eoc_pending_q  <= eoc_pending_d;
`ifdef XADC_SEQ_AVG_EN
            primed_q       <= primed_d;
`endif
        end
    end

    assign daddr_out    = daddr_q;
    assign den_out      = den_q;
    assign dwe_out      = 1'b0;
    assign di_out       = 16'h0000;
    assign result0      = result_q[0];
    assign result1      = result_q[1];
    assign result2      = result_q[2];
    assign result3      = result_q[3];
    assign result_valid = result_valid_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign overrun_err  = overrun_err_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xadc_drp_sequencer
//
// Directed bench for xadc_drp_sequencer with a small DRP responder model.
// The responder answers each den_out after a programmable latency, either
// with a fixed word or with the DRP address placed in the upper bits, and
// can be told to ignore one address. A negedge monitor logs DRP addresses,
// valid pulses and frame_done pulses for ordering and counting checks.
// ---------------------------------------------------------------------------
module tb_xadc_drp_sequencer;

    logic        clk;
    logic        reset_in;
    logic        eoc_in;
    logic [3:0]  ch_mask;
    logic        clr_err;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in;
    logic        drdy_in;
    logic [11:0] result0, result1, result2, result3;
    logic [3:0]  result_valid;
    logic        frame_done;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    // Responder model controls (written only by the main sequence).
    logic        model_on;
    int          model_lat;
    logic [6:0]  mute_addr;
    logic        addr_data;
    logic [15:0] resp_data;
    logic        model_drdy;
    logic [15:0] model_data;
    logic        force_drdy;
    logic [15:0] force_data;

    int errors = 0;
    int checks = 0;

    // Monitor records (written only by the monitor).
    int         den_count = 0;
    int         fd_count = 0;
    int         valid_count [4] = '{0, 0, 0, 0};
    logic [6:0] addr_log [$];
    logic [3:0] valid_log [$];

    assign drdy_in = model_drdy | force_drdy;
    assign do_in   = force_drdy ? force_data : model_data;

    xadc_drp_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .CLK100MHZ    (clk),
        .reset_in     (reset_in),
        .eoc_in       (eoc_in),
        .ch_mask      (ch_mask),
        .clr_err      (clr_err),
        .daddr_out    (daddr_out),
        .den_out      (den_out),
        .dwe_out      (dwe_out),
        .di_out       (di_out),
        .do_in        (do_in),
        .drdy_in      (drdy_in),
        .result0      (result0),
        .result1      (result1),
        .result2      (result2),
        .result3      (result3),
        .result_valid (result_valid),
        .frame_done   (frame_done),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRP responder: drdy is driven so the DUT samples it model_lat edges after den.
    initial begin
        logic [6:0] a;
        model_drdy = 1'b0;
        model_data = 16'h0000;
        forever begin
            @(negedge clk);
            model_drdy = 1'b0;
            if (den_out && model_on && daddr_out != mute_addr) begin
                a = daddr_out;
                repeat (model_lat - 1) @(negedge clk);
                model_drdy = 1'b1;
                model_data = addr_data ? {a, 9'h000} : resp_data;
            end
        end
    end

    always @(negedge clk) begin
        if (den_out) begin
            den_count++;
            addr_log.push_back(daddr_out);
        end
        if (frame_done) fd_count++;
        for (int i = 0; i < 4; i++) if (result_valid[i]) valid_count[i]++;
        if (result_valid != 4'b0000) valid_log.push_back(result_valid);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; leaves eoc high for exactly one sampling edge.
    task automatic applyStimulus(input logic [3:0] mask);
        ch_mask = mask;
        eoc_in  = 1'b1;
        @(negedge clk);
        eoc_in  = 1'b0;
    endtask

    task automatic waitFrame(input string tag, input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_frame_seen"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int f0, d0, a0, vl0, v0, v1, n;
        reset_in   = 1'b1;
        eoc_in     = 1'b0;
        ch_mask    = 4'b0000;
        clr_err    = 1'b0;
        force_drdy = 1'b0;
        force_data = 16'h0000;
        model_on   = 1'b1;
        model_lat  = 3;
        mute_addr  = 7'h7F;
        addr_data  = 1'b0;
        resp_data  = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_den", 32'(den_out), 32'd0);
        checkOutput("rst_daddr", 32'(daddr_out), 32'd0);
        checkOutput("rst_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_result0", 32'(result0), 32'd0);
        checkOutput("rst_terr", 32'(timeout_err), 32'd0);
        checkOutput("rst_oerr", 32'(overrun_err), 32'd0);
        checkOutput("rst_dwe_di", {15'd0, dwe_out, di_out}, 32'd0);
        reset_in = 1'b0;
        repeat (2) @(negedge clk);

        // Single channel VAUX2
        $display("[TB] single channel");
        resp_data = 16'hABC0;
        f0 = fd_count;
        v1 = valid_count[1];
        applyStimulus(4'b0010);
        checkOutput("single_den_latency", 32'(den_out), 32'd1);
        checkOutput("single_daddr", 32'(daddr_out), 32'h12);
        waitFrame("single", 20);
        checkOutput("single_result1", 32'(result1), 32'hABC);
        checkOutput("single_valid_with_fd", 32'(result_valid), 32'h2);
        @(negedge clk);
        #1;
        checkOutput("single_busy_after", 32'(busy), 32'd0);
        checkOutput("single_valid_count", 32'(valid_count[1] - v1), 32'd1);
        checkOutput("single_frames", 32'(fd_count - f0), 32'd1);

        // Full scan, data = address in the upper bits
        $display("[TB] full scan");
        repeat (2) @(negedge clk);
        addr_data = 1'b1;
        a0  = addr_log.size();
        vl0 = valid_log.size();
        f0  = fd_count;
        applyStimulus(4'b1111);
        waitFrame("scan", 60);
        checkOutput("scan_last_valid", 32'(result_valid), 32'h8);
        #1;
        checkOutput("scan_den_count", 32'(addr_log.size() - a0), 32'd4);
        checkOutput("scan_addr0", 32'(addr_log[a0]), 32'h03);
        checkOutput("scan_addr1", 32'(addr_log[a0 + 1]), 32'h12);
        checkOutput("scan_addr2", 32'(addr_log[a0 + 2]), 32'h13);
        checkOutput("scan_addr3", 32'(addr_log[a0 + 3]), 32'h1A);
        checkOutput("scan_valid_order", {valid_log[vl0 + 3], valid_log[vl0 + 2], valid_log[vl0 + 1], valid_log[vl0]}, 32'h8421);
        checkOutput("scan_result0", 32'(result0), 32'h060);
        checkOutput("scan_result1", 32'(result1), 32'h240);
        checkOutput("scan_result2", 32'(result2), 32'h260);
        checkOutput("scan_result3", 32'(result3), 32'h340);
        checkOutput("scan_frames", 32'(fd_count - f0), 32'd1);
        addr_data = 1'b0;

        // Timeout on VP/VN, VAUX3 still read
        $display("[TB] timeout");
        repeat (2) @(negedge clk);
        resp_data = 16'h5A50;
        mute_addr = 7'h03;
        v0 = valid_count[0];
        f0 = fd_count;
        applyStimulus(4'b0101);
        checkOutput("to_daddr", 32'(daddr_out), 32'h03);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_cycles_after_den", 32'(n), 32'd9);
        waitFrame("to", 40);
        #1;
        checkOutput("to_result0_kept", 32'(result0), 32'h060);
        checkOutput("to_result2", 32'(result2), 32'h5A5);
        checkOutput("to_no_valid0", 32'(valid_count[0] - v0), 32'd0);
        checkOutput("to_frames", 32'(fd_count - f0), 32'd1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("to_cleared", 32'(timeout_err), 32'd0);
        mute_addr = 7'h7F;

        // drdy on the very last allowed WAIT cycle: capture wins
        $display("[TB] drdy at timeout limit");
        repeat (2) @(negedge clk);
        model_lat = 9;
        resp_data = 16'h1230;
        v0 = valid_count[0];
        applyStimulus(4'b0001);
        waitFrame("edge", 30);
        #1;
        checkOutput("edge_result0", 32'(result0), 32'h123);
        checkOutput("edge_no_terr", 32'(timeout_err), 32'd0);
        checkOutput("edge_valid0", 32'(valid_count[0] - v0), 32'd1);
        model_lat = 3;

        // EOC overrun: first extra EOC queued, second sets overrun_err
        $display("[TB] eoc overrun");
        repeat (2) @(negedge clk);
        resp_data = 16'h0010;
        f0 = fd_count;
        applyStimulus(4'b0001);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        @(negedge clk);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        waitFrame("ovr1", 10);
        checkOutput("ovr_err_set", 32'(overrun_err), 32'd1);
        @(negedge clk);
        checkOutput("ovr_idle_busy", 32'(busy), 32'd0);
        checkOutput("ovr_idle_den", 32'(den_out), 32'd0);
        @(negedge clk);
        checkOutput("ovr_restart_den", 32'(den_out), 32'd1);
        waitFrame("ovr2", 20);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("ovr_frames", 32'(fd_count - f0), 32'd2);
        checkOutput("ovr_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun_err), 32'd0);

        // EOC with an empty mask is ignored
        $display("[TB] empty mask");
        repeat (2) @(negedge clk);
        d0 = den_count;
        f0 = fd_count;
        applyStimulus(4'b0000);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("zero_no_den", 32'(den_count - d0), 32'd0);
        checkOutput("zero_no_frame", 32'(fd_count - f0), 32'd0);

        // Reset in WAIT, then a stray drdy
        $display("[TB] reset mid-wait");
        repeat (2) @(negedge clk);
        model_on = 1'b0;
        v0 = valid_count[0];
        f0 = fd_count;
        applyStimulus(4'b0001);
        @(negedge clk);
        checkOutput("rstw_busy_before", 32'(busy), 32'd1);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in   = 1'b0;
        force_drdy = 1'b1;
        force_data = 16'hFFF0;
        checkOutput("rstw_busy", 32'(busy), 32'd0);
        checkOutput("rstw_daddr", 32'(daddr_out), 32'd0);
        checkOutput("rstw_result1", 32'(result1), 32'd0);
        @(negedge clk);
        force_drdy = 1'b0;
        checkOutput("rstw_result0", 32'(result0), 32'd0);
        checkOutput("rstw_valid", 32'(result_valid), 32'd0);
        checkOutput("rstw_busy2", 32'(busy), 32'd0);
        #1;
        checkOutput("rstw_no_valid", 32'(valid_count[0] - v0), 32'd0);
        checkOutput("rstw_no_frame", 32'(fd_count - f0), 32'd0);
        model_on = 1'b1;

        // Two captures on channel 0 after reset
        $display("[TB] result update path");
        repeat (2) @(negedge clk);
        resp_data = 16'h4000;
        applyStimulus(4'b0001);
        waitFrame("avg1", 20);
        checkOutput("avg_first", 32'(result0), 32'h400);
        repeat (2) @(negedge clk);
        resp_data = 16'h8000;
        applyStimulus(4'b0001);
        waitFrame("avg2", 20);
`ifdef XADC_SEQ_AVG_EN
        checkOutput("avg_second", 32'(result0), 32'h500);
`else
        checkOutput("raw_second", 32'(result0), 32'h800);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
